multiplier_top_rv32m: RTL and testbench

Pipelined RV32M multiply unit with an integrated instruction decoder. It sits in the execute stage beside the ALU. It accepts raw R-type opcode/funct fields plus two 32-bit register operands and returns the 32-bit MUL/MULH/MULHSU/MULHU result after a fixed 3-cycle latency. Division encodings are recognised and rejected, so they can be routed to a separate divider.

---
 rtl/multiplier_top_rv32m.sv | 126 ++++++++++++
 tb/tb_multiplier_top_rv32m.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_top_rv32m.sv
// ============================================================================
// multiplier_top_rv32m : 3-stage pipelined RV32M multiplier with built-in decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module multiplier_top_rv32m (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] op_A_i,
  input  logic [31:0] op_B_i,
  output logic [31:0] result_o,
  output logic        done_o
);

  localparam logic [6:0] C_OPCODE_OP = 7'b0110011;
  localparam logic [6:0] C_FUNCT7_M  = 7'b0000001;

  logic        w_mult_en;
  logic        w_signed_a;
  logic        w_signed_b;
  logic        w_upper;

  assign w_mult_en  = (opcode_i == C_OPCODE_OP) && (funct7_i == C_FUNCT7_M) && !funct3_i[2];
  assign w_signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010);
  assign w_signed_b = (funct3_i == 3'b001);
  assign w_upper    = (funct3_i != 3'b000);

  // Stage 1: 33-bit operands carrying the per-instruction signedness
  logic [32:0] r_s1_a;
  logic [32:0] r_s1_b;
  logic        r_s1_valid;
  logic        r_s1_upper;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_upper <= 1'b0;
    end else begin
      r_s1_a     <= {w_signed_a & op_A_i[31], op_A_i};
      r_s1_b     <= {w_signed_b & op_B_i[31], op_B_i};
      r_s1_valid <= w_mult_en;
      r_s1_upper <= w_upper;
    end
  end

  // Stage 2: signed 17-bit high pieces, unsigned 16-bit low pieces. Each
  // operand is extended to the 34-bit product width so a plain modular
  // multiply yields the exact two's-complement partial product.
  logic [33:0] w_a_hi;
  logic [33:0] w_b_hi;
  logic [33:0] w_a_lo;
  logic [33:0] w_b_lo;
  logic [33:0] w_pp_hh;
  logic [33:0] w_pp_hl;
  logic [33:0] w_pp_lh;
  logic [31:0] w_pp_ll;

  assign w_a_hi  = {{17{r_s1_a[32]}}, r_s1_a[32:16]};
  assign w_b_hi  = {{17{r_s1_b[32]}}, r_s1_b[32:16]};
  assign w_a_lo  = {18'd0, r_s1_a[15:0]};
  assign w_b_lo  = {18'd0, r_s1_b[15:0]};
  assign w_pp_hh = w_a_hi * w_b_hi;
  assign w_pp_hl = w_a_hi * w_b_lo;
  assign w_pp_lh = w_a_lo * w_b_hi;
  assign w_pp_ll = r_s1_a[15:0] * r_s1_b[15:0];

  logic [33:0] r_pp_hh;
  logic [33:0] r_pp_hl;
  logic [33:0] r_pp_lh;
  logic [31:0] r_pp_ll;
  logic        r_s2_valid;
  logic        r_s2_upper;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pp_hh    <= '0;
      r_pp_hl    <= '0;
      r_pp_lh    <= '0;
      r_pp_ll    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_upper <= 1'b0;
    end else begin
      r_pp_hh    <= w_pp_hh;
      r_pp_hl    <= w_pp_hl;
      r_pp_lh    <= w_pp_lh;
      r_pp_ll    <= w_pp_ll;
      r_s2_valid <= r_s1_valid;
      r_s2_upper <= r_s1_upper;
    end
  end

  // Stage 3: align and sum partials into the 66-bit product
  logic [65:0] w_prod;

  assign w_prod = {r_pp_hh, 32'd0}
                + {{16{r_pp_hl[33]}}, r_pp_hl, 16'd0}
                + {{16{r_pp_lh[33]}}, r_pp_lh, 16'd0}
                + {34'd0, r_pp_ll};

  logic [31:0] r_result;
  logic        r_done;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= r_s2_valid;
      if (r_s2_valid) begin
        r_result <= r_s2_upper ? w_prod[63:32] : w_prod[31:0];
      end
    end
  end

  assign result_o = r_result;
  assign done_o   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_top_rv32m.sv
// ============================================================================
// tb_multiplier_top_rv32m : scoreboard bench for the pipelined RV32M multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multiplier_top_rv32m;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] op_A_i = '0;
  logic [31:0] op_B_i = '0;
  logic [31:0] result_o;
  logic        done_o;

  localparam logic [6:0] C_OP  = 7'b0110011;
  localparam logic [6:0] C_F7M = 7'b0000001;

  multiplier_top_rv32m u_dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .opcode_i (opcode_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .op_A_i   (op_A_i),
    .op_B_i   (op_B_i),
    .result_o (result_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        vld;
    logic [31:0] res;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  logic [31:0] last_res = '0;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // One cycle: retire the op issued three cycles ago, then drive the next one
  task automatic step(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic vld, input logic [31:0] res, input string tag);
    exp_t  e;
    string t;
    @(negedge clk_i);
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.vld) last_res = e.res;
      check({t, "_done"}, {31'd0, done_o}, {31'd0, e.vld});
      check({t, "_result"}, result_o, last_res);
    end
    opcode_i = opc;
    funct3_i = f3;
    funct7_i = f7;
    op_A_i   = a;
    op_B_i   = b;
    exp_q.push_back('{vld: vld, res: res});
    tag_q.push_back(tag);
  endtask

  task automatic mul_const(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input string tag);
    step(C_OP, f3, C_F7M, a, b, 1'b1, res, tag);
  endtask

  task automatic idle(input string tag);
    step(7'd0, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'd0, tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rf;

    repeat (2) @(negedge clk_i);
    check("reset_result", result_o, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b1;

    // Mixed-sign operands, all four variants back to back
    mul_const(3'b000, 32'h8000_0001, 32'h8001_0002, 32'h8001_0002, "mul_a");
    mul_const(3'b001, 32'h8000_0001, 32'h8001_0002, 32'h3FFF_7FFE, "mulh_a");
    mul_const(3'b010, 32'h8000_0001, 32'h8001_0002, 32'hBFFF_7FFF, "mulhsu_a");
    mul_const(3'b011, 32'h8000_0001, 32'h8001_0002, 32'h4000_8001, "mulhu_a");
    mul_const(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff");
    mul_const(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
    mul_const(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
    mul_const(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff");

    // Rejected encodings leave result_o at its last value
    step(C_OP,       3'b100, C_F7M, 32'd7, 32'd9, 1'b0, 32'd0, "rej_div");
    step(C_OP,       3'b000, 7'd0,  32'd7, 32'd9, 1'b0, 32'd0, "rej_f7");
    step(7'b0010011, 3'b000, C_F7M, 32'd7, 32'd9, 1'b0, 32'd0, "rej_opc");
    step(C_OP,       3'b111, C_F7M, 32'd7, 32'd9, 1'b0, 32'd0, "rej_rem");

    // Held inputs re-issue the same op each cycle
    repeat (3) mul_const(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "hold");

    // Random back-to-back traffic with occasional bubbles
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 3'($urandom_range(0, 3));
      if (i % 4 == 0) begin
        ra[31] = 1'b1;
        rb[31] = (i % 8 == 0);
      end
      if ($urandom_range(0, 5) == 0) idle("rnd_bubble");
      else step(C_OP, rf, C_F7M, ra, rb, 1'b1, ref_mul(rf, ra, rb), "rnd");
    end
    repeat (3) idle("flush");

    // Reset one cycle after issuing MULHU: outputs clear at once, no done follows
    mul_const(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_killed");
    @(negedge clk_i);
    opcode_i = 7'd0;
    rst_i    = 1'b0;
    #1;
    check("midrst_result", result_o, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    exp_q.delete();
    tag_q.delete();
    last_res = 32'd0;
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (6) idle("post_rst");
    mul_const(3'b000, 32'd12345, 32'd6789, 32'd83810205, "post_rst_mul");
    repeat (3) idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
